// File: rtl/add_signed_accum_if.sv
// Operand/result handshake bundle for add_signed_accum.
// master = operand source and result consumer, slave = the accumulator.
interface add_signed_accum_if #(
  parameter int DATA_WIDTH = 9,
  parameter int BEATS      = 4
);
  localparam int ACC_W = DATA_WIDTH + 2 + $clog2(BEATS);
  localparam int CNT_W = $clog2(BEATS);

  logic signed [DATA_WIDTH:0] A;
  logic                       sub;
  logic                       in_valid;
  logic                       in_ready;
  logic signed [ACC_W-1:0]    sum;
  logic                       out_valid;
  logic                       out_ready;
  logic [CNT_W-1:0]           beat_cnt;
  logic                       sat;

  modport master (
    output A, sub, in_valid, out_ready,
    input  in_ready, sum, out_valid, beat_cnt, sat
  );

  modport slave (
    input  A, sub, in_valid, out_ready,
    output in_ready, sum, out_valid, beat_cnt, sat
  );
endinterface

// File: rtl/add_signed_accum.sv
// Streaming signed add/subtract accumulator: one widened block sum every BEATS operands.
// Define ACC_SAT_EN to clamp each result to the DATA_WIDTH+2-bit signed range and flag sat.
module add_signed_accum #(
  parameter int DATA_WIDTH = 9,
  parameter int BEATS      = 4
) (
  input logic                clk,
  input logic                rst,
  input logic                clr,
  add_signed_accum_if.slave  bus
);
  localparam int ACC_W = DATA_WIDTH + 2 + $clog2(BEATS);
  localparam int CNT_W = $clog2(BEATS);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sat_q, sat_d;

  logic signed [ACC_W-1:0] a_ext;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] result;
  logic                    clamp_hit;
  logic                    last_beat;

  assign a_ext     = {{(ACC_W-DATA_WIDTH-1){bus.A[DATA_WIDTH]}}, bus.A};
  assign acc_next  = bus.sub ? (acc_q - a_ext) : (acc_q + a_ext);
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

`ifdef ACC_SAT_EN
  // Output range of the original two-operand adder; ~MAX is exactly -2^(DATA_WIDTH+1).
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_WIDTH + 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    result    = acc_next;
    clamp_hit = 1'b0;
    if (acc_next > SAT_MAX) begin
      result    = SAT_MAX;
      clamp_hit = 1'b1;
    end else if (acc_next < SAT_MIN) begin
      result    = SAT_MIN;
      clamp_hit = 1'b1;
    end
  end
`else
  assign result    = acc_next;
  assign clamp_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (clr) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else if (state_q == ST_ACCUM) begin
      if (bus.in_valid) begin
        if (last_beat) begin
          sum_d   = result;
          sat_d   = clamp_hit;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          acc_d = acc_next;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else if (bus.out_ready) begin
      // Handoff cycle accepts no operand: one bubble per block.
      state_d = ST_ACCUM;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.sum       = sum_q;
  assign bus.beat_cnt  = cnt_q;
  assign bus.sat       = sat_q;
endmodule

// File: tb/tb_add_signed_accum.sv
// Self-checking bench for add_signed_accum (DATA_WIDTH=9, BEATS=4, ACC_W=13).
// Expected sums/sat follow ACC_SAT_EN when the bench is built with it defined.
module tb_add_signed_accum;
  localparam int DW    = 9;
  localparam int BEATS = 4;
  localparam int ACC_W = 13;

  logic clk;
  logic rst;
  logic clr;

  add_signed_accum_if #(.DATA_WIDTH(DW), .BEATS(BEATS)) bus ();

  add_signed_accum #(.DATA_WIDTH(DW), .BEATS(BEATS)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [ACC_W-1:0] sum;
    logic                    sat;
  } exp_t;

  typedef struct packed {
    logic [3:0][DW:0]        a;
    logic [3:0]              sub;
    logic signed [ACC_W-1:0] exp_raw;
    logic signed [ACC_W-1:0] exp_clamp;
    logic                    exp_sat;
  } vec_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   m_acc = 0;
  int   m_cnt = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for one accepted operand; pushes the expected result on the last beat.
  task automatic model_accept(input int a, input bit s);
    exp_t e;
    m_acc = s ? (m_acc - a) : (m_acc + a);
    m_cnt++;
    if (m_cnt == BEATS) begin
      e.sum = ACC_W'(m_acc);
      e.sat = 1'b0;
`ifdef ACC_SAT_EN
      if (m_acc > 1023) begin
        e.sum = 13'sd1023;
        e.sat = 1'b1;
      end else if (m_acc < -1024) begin
        e.sum = -13'sd1024;
        e.sat = 1'b1;
      end
`endif
      sb_q.push_back(e);
      m_acc = 0;
      m_cnt = 0;
    end
  endtask

  // One clock of stimulus, called just after an active edge.
  task automatic drive_cycle(input bit v, input int a, input bit s, input bit c);
    bit acc;
    bus.in_valid = v;
    bus.A        = (DW+1)'(a);
    bus.sub      = s;
    clr          = c;
    acc          = v && bus.in_ready && !c;
    @(posedge clk);
    #1;
    if (c) begin
      m_acc = 0;
      m_cnt = 0;
    end else if (acc) begin
      model_accept(a, s);
    end
    bus.in_valid = 1'b0;
    clr          = 1'b0;
  endtask

  task automatic send_beat(input int a, input bit s);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 0, 1);
    else drive_cycle(1'b1, a, s, 1'b0);
  endtask

  task automatic collect();
    int n = 0;
    bus.out_ready = 1'b1;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) check("collect_timeout", 32'(sb_q.size()), 0);
    bus.out_ready = 1'b0;
  endtask

  // Scoreboard: compare at the falling edge preceding each handoff edge.
  always @(negedge clk) begin
    if (!rst && !clr && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_sum", bus.sum, e.sum);
        check("sb_sat", 32'(bus.sat), 32'(e.sat));
      end
    end
  end

  function automatic vec_t mk(input int a0, a1, a2, a3, input bit s0, s1, s2, s3,
                              input int raw, input int clamp, input bit st);
    vec_t v;
    v.a[0]      = (DW+1)'(a0);
    v.a[1]      = (DW+1)'(a1);
    v.a[2]      = (DW+1)'(a2);
    v.a[3]      = (DW+1)'(a3);
    v.sub       = {s3, s2, s1, s0};
    v.exp_raw   = ACC_W'(raw);
    v.exp_clamp = ACC_W'(clamp);
    v.exp_sat   = st;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   gap_v[7];
    int   gap_a[7];

    vecs[0] = mk(-512, -512, -512, -512, 1, 1, 1, 1, 2048, 1023, 1'b1);
    vecs[1] = mk(-512, -512, -512, -512, 0, 0, 0, 0, -2048, -1024, 1'b1);
    vecs[2] = mk(511, 511, 511, 511, 0, 0, 0, 0, 2044, 1023, 1'b1);
    vecs[3] = mk(100, -200, 300, -50, 0, 1, 0, 1, 650, 650, 1'b0);
    vecs[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    vecs[5] = mk(-300, 200, -400, 100, 0, 1, 0, 1, -1000, -1000, 1'b0);

    gap_v = '{1, 0, 0, 1, 0, 1, 1};
    gap_a = '{5, 0, 0, 7, 0, -2, 10};

    rst           = 1'b1;
    clr           = 1'b0;
    bus.A         = '0;
    bus.sub       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    check("rst_sum", bus.sum, 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_beat_cnt", 32'(bus.beat_cnt), 0);
    check("rst_sat", 32'(bus.sat), 0);

    // Add block with in_valid held high; beat_cnt runs 0,1,2,3,0.
    send_beat(1, 0);  check("add_cnt1", 32'(bus.beat_cnt), 1);
    send_beat(3, 0);  check("add_cnt2", 32'(bus.beat_cnt), 2);
    send_beat(-1, 0); check("add_cnt3", 32'(bus.beat_cnt), 3);
    send_beat(3, 0);  check("add_cnt0", 32'(bus.beat_cnt), 0);
    check("add_out_valid", 32'(bus.out_valid), 1);
    check("add_in_ready", 32'(bus.in_ready), 0);
    check("add_sum", bus.sum, 6);
    collect();

    // Mixed add/sub under 3 cycles of back-pressure.
    send_beat(-255, 0);
    send_beat(-256, 0);
    send_beat(-9, 1);
    send_beat(19, 1);
    for (int i = 0; i < 3; i++) begin
      check("bp_sum", bus.sum, -521);
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp_release_out_valid", 32'(bus.out_valid), 0);
    check("bp_release_in_ready", 32'(bus.in_ready), 1);
    check("bp_queue_drained", 32'(sb_q.size()), 0);

    // Table of full blocks, including the extreme operands.
    for (int k = 0; k < 6; k++) begin
      for (int b = 0; b < BEATS; b++)
        send_beat(int'($signed(vecs[k].a[b])), vecs[k].sub[b]);
`ifdef ACC_SAT_EN
      check("vec_sum", bus.sum, vecs[k].exp_clamp);
      check("vec_sat", 32'(bus.sat), 32'(vecs[k].exp_sat));
`else
      check("vec_sum", bus.sum, vecs[k].exp_raw);
      check("vec_sat", 32'(bus.sat), 0);
`endif
      collect();
    end

    // Gaps in in_valid: only valid beats count.
    for (int i = 0; i < 7; i++)
      drive_cycle(gap_v[i] != 0, gap_v[i] != 0 ? gap_a[i] : int'($urandom_range(0, 1023)) - 512,
                  1'($urandom_range(0, 1)) & (gap_v[i] == 0), 1'b0);
    check("gap_out_valid", 32'(bus.out_valid), 1);
    check("gap_sum", bus.sum, 20);
    collect();

    // clr coincident with a third beat drops the partial block and the 50.
    send_beat(100, 0);
    send_beat(100, 0);
    check("abort_cnt_pre", 32'(bus.beat_cnt), 2);
    drive_cycle(1'b1, 50, 1'b0, 1'b1);
    check("abort_cnt_post", 32'(bus.beat_cnt), 0);
    for (int i = 0; i < 4; i++) send_beat(1, 0);
    check("abort_sum", bus.sum, 4);
    collect();

    // clr in HOLD wins over out_ready; sum keeps its value but is invalid.
    for (int i = 0; i < 4; i++) send_beat(2, 0);
    check("clrhold_sum_pre", bus.sum, 8);
    bus.out_ready = 1'b1;
    drive_cycle(1'b0, 0, 1'b0, 1'b1);
    bus.out_ready = 1'b0;
    void'(sb_q.pop_back());
    check("clrhold_out_valid", 32'(bus.out_valid), 0);
    check("clrhold_in_ready", 32'(bus.in_ready), 1);
    check("clrhold_sat", 32'(bus.sat), 0);
    check("clrhold_sum_kept", bus.sum, 8);

    // Asynchronous reset mid-cycle while holding a result.
    send_beat(1, 0);
    send_beat(3, 0);
    send_beat(-1, 0);
    send_beat(3, 0);
    check("arst_sum_pre", bus.sum, 6);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 0);
    check("arst_in_ready", 32'(bus.in_ready), 1);
    check("arst_sum", bus.sum, 0);
    check("arst_beat_cnt", 32'(bus.beat_cnt), 0);
    sb_q.delete();
    m_acc = 0;
    m_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // One more block after reset to confirm clean restart.
    send_beat(7, 0);
    send_beat(-3, 1);
    send_beat(0, 0);
    send_beat(-20, 0);
    check("post_rst_sum", bus.sum, -10);
    collect();

    check("final_queue_empty", 32'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/add_signed_accum.md
Name: add_signed_accum

Overview:
- Parametrised, sequential successor to the combinational signed adder.
- Accepts a stream of signed DATA_WIDTH+1-bit operands over a valid/ready handshake.
- Adds or subtracts each operand into a widened accumulator, and emits one signed result every BEATS accepted operands.
- Sits between sample sources and downstream signed datapaths (filters, averagers) that need block sums without overflow.

Parameters:
- DATA_WIDTH, 9: operand is DATA_WIDTH+1 bits, two's complement (matches the existing adder convention).
- BEATS, 4: operands per result, ≥2.
- ACC_W, DATA_WIDTH+2+$clog2(BEATS): accumulator and result width (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous abort; discards the partial sum and any held result
- A  input  DATA_WIDTH+1  signed operand
- sub  input  1  1 = subtract A this beat, 0 = add
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand
- sum  output  ACC_W  signed block result
- out_valid  output  1  sum valid
- out_ready  input  1  consumer accepts sum
- beat_cnt  output  $clog2(BEATS)  operands accepted in the current block
- sat  output  1  result was clamped (only meaningful with ACC_SAT_EN)

Behaviour:
- Interface decision: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: sum=0, out_valid=0, in_ready=1, beat_cnt=0, sat=0, accumulator=0, state=ACCUM.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- ACCUM, operand accepted (in_valid & in_ready):
  - acc <= acc ± sign-extended A.
  - beat_cnt increments.
- ACCUM, last operand accepted (beat_cnt==BEATS-1):
  - sum <= final acc value, including this operand.
  - acc <= 0, beat_cnt <= 0, state <= HOLD.
  - Latency: out_valid rises on the edge that accepts the last operand, so it is high in the next cycle.
- HOLD:
  - sum and sat are stable while out_valid & !out_ready.
  - On out_ready: out_valid <= 0, state <= ACCUM, in_ready=1 the next cycle.
  - No operand is accepted in the same cycle as the result handoff; the cost is one bubble per block.
- Arithmetic:
  - ACC_W is sized so BEATS × (−2^DATA_WIDTH) subtracted cannot overflow (the negated minimum needs one extra bit).
  - Without saturation there is no wrap in any case.
- in_valid low in ACCUM: acc and beat_cnt hold.
- sub is sampled only on accepted beats.
- clr:
  - Forces acc=0, beat_cnt=0, out_valid=0, sat=0, state=ACCUM on the next edge.
  - clr overrides a simultaneous operand accept or out_ready.
  - sum keeps its last value but is invalid.
- rst asserted mid-block or in HOLD: immediate return to reset values; the partial sum is lost.
- out_ready while out_valid=0: ignored.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined:
  - The final result is clamped to the range of a DATA_WIDTH+2-bit signed value, [−2^(DATA_WIDTH+1), 2^(DATA_WIDTH+1)−1], which is the output range of the existing two-operand adder. The clamped value is sign-extended onto sum.
  - sat=1 for that result if clamping occurred.
  - The internal accumulator stays full width; clamping is applied only when loading sum.
- Undefined:
  - sum is the exact full-width result.
  - sat is tied to 0.

Test Plan (DATA_WIDTH=9, BEATS=4, ACC_W=13):
- Add block: A = 1, 3, −1, 3, all sub=0, in_valid held high → out_valid high one cycle after the 4th accept, sum=6; beat_cnt sequence 0, 1, 2, 3, 0.
- Mixed add/sub: (−255, add), (−256, add), (−9, sub), (19, sub) with out_ready=0 for 3 cycles → sum=−521 held stable with out_valid=1 and in_ready=0 for 3 cycles; clears one cycle after out_ready.
- Extremes: four beats of −512 with sub=1 →
  - without macro: sum=2048, sat=0;
  - with ACC_SAT_EN: sum=1023, sat=1.
  - Four beats of −512 with sub=0: sum=−2048 (without macro), or −1024 with sat=1 (with macro).
- Gaps: in_valid toggled 1, 0, 0, 1, 0, 1, 1 carrying A = 5, x, x, 7, x, −2, 10 → only valid beats are counted; sum=20.
- Abort: accept 2 beats (100, 100), assert clr coincident with a 3rd valid beat (50), then send 4 beats of 1 → the first result after clr is sum=4; the 50 is dropped.
- Async reset: assert rst mid-cycle in HOLD with sum=6 → out_valid=0, in_ready=1, sum=0, beat_cnt=0 immediately, without waiting for a clk edge.
